// File: rtl/decode_queue_if.sv
// Fetch/execute handshake bundle for decode_queue: the fetch side, the execute side
// (the head entry plus its decoded control bundle), flush and occupancy.
interface decode_queue_if #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [2:0]         result_src;
    logic               mem_write;
    logic               alu_src;
    logic [2:0]         imm_src;
    logic               reg_write;
    logic               branch;
    logic               jump;
    logic [2:0]         alu_ctl;
    logic [4:0]         fpu_ctl;
    logic               is_fpu;
    logic               is_jalr;
    logic               is_load;
    logic               is_in;
    logic               is_out;
    logic               illegal;
    logic [CW-1:0]      count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, result_src, mem_write, alu_src,
               imm_src, reg_write, branch, jump, alu_ctl, fpu_ctl, is_fpu, is_jalr,
               is_load, is_in, is_out, illegal, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, result_src, mem_write, alu_src,
               imm_src, reg_write, branch, jump, alu_ctl, fpu_ctl, is_fpu, is_jalr,
               is_load, is_in, is_out, illegal, count
    );
endinterface

// File: rtl/decode_queue.sv
// Decode stage: decodes at enqueue and buffers control bundles in a DEPTH-entry FIFO.
// The head is presented to execute; every output reads 0 while the queue is empty.
module decode_queue #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int OP_LSB  = 0,
    parameter int F3_LSB  = 4
) (
    input logic          clk,
    input logic          rstn,
    decode_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [3:0] OP_LW = 4'h0, OP_I = 4'h1, OP_JALR = 4'h2, OP_LUI = 4'h3,
                           OP_AUIPC = 4'h4, OP_S = 4'h5, OP_R = 4'h6, OP_BI = 4'h7,
                           OP_B = 4'h8, OP_JAL = 4'h9, OP_IN = 4'hA, OP_OUT = 4'hB,
                           OP_RF = 4'hC, OP_C = 4'hD, OP_BF = 4'hE, OP_ILL = 4'hF;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [2:0]         result_src;
        logic               mem_write;
        logic               alu_src;
        logic [2:0]         imm_src;
        logic               reg_write;
        logic               branch;
        logic               jump;
        logic [2:0]         alu_ctl;
        logic [4:0]         fpu_ctl;
        logic               is_fpu;
        logic               is_jalr;
        logic               is_load;
        logic               is_in;
        logic               is_out;
        logic               illegal;
    } entry_t;

    logic [3:0]    op;
    logic [2:0]    f3;
    entry_t        dec;
    entry_t        head;
    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    assign op = q.in_instr[OP_LSB+3:OP_LSB];
    assign f3 = q.in_instr[F3_LSB+2:F3_LSB];

    always_comb begin
        dec            = '0;
        dec.instr      = q.in_instr;
        dec.pc         = q.in_pc;
        dec.alu_ctl    = f3;
        dec.imm_src    = 3'b111;
        dec.illegal    = (op == OP_ILL);
        dec.is_fpu     = (op[3:2] == 2'b11) && !dec.illegal;
        dec.fpu_ctl    = dec.is_fpu ? {op[1:0], f3} : 5'b11111;
        case (op)
            OP_LW:    begin dec.result_src = 3'b001; dec.alu_src = 1'b1; dec.imm_src = 3'b000;
                            dec.reg_write = 1'b1; dec.is_load = 1'b1; end
            OP_I:     begin dec.alu_src = 1'b1; dec.imm_src = 3'b000; dec.reg_write = 1'b1; end
            OP_JALR:  begin dec.result_src = 3'b010; dec.alu_src = 1'b1; dec.imm_src = 3'b000;
                            dec.reg_write = 1'b1; dec.jump = 1'b1; dec.is_jalr = 1'b1; end
            OP_LUI:   begin dec.result_src = 3'b011; dec.imm_src = 3'b001; dec.reg_write = 1'b1; end
            OP_AUIPC: begin dec.result_src = 3'b100; dec.imm_src = 3'b001; dec.reg_write = 1'b1; end
            OP_S:     begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.imm_src = 3'b010; end
            OP_R:     dec.reg_write = 1'b1;
            OP_BI:    begin dec.alu_src = 1'b1; dec.imm_src = 3'b011; dec.branch = 1'b1; end
            OP_B:     begin dec.imm_src = 3'b010; dec.branch = 1'b1; end
            OP_JAL:   begin dec.result_src = 3'b010; dec.imm_src = 3'b100; dec.reg_write = 1'b1;
                            dec.jump = 1'b1; end
            OP_IN:    begin dec.result_src = 3'b001; dec.reg_write = 1'b1; dec.is_in = 1'b1; end
            OP_OUT:   dec.is_out = 1'b1;
            OP_RF:    dec.reg_write = 1'b1;
            OP_C:     dec.reg_write = 1'b1;
            OP_BF:    begin dec.imm_src = 3'b010; dec.branch = 1'b1; end
            default:  dec.result_src = 3'b111;
        endcase
    end

    assign q.in_ready  = rstn && (count < CW'(DEPTH));
    assign q.out_valid = rstn && (count != '0);
    assign q.count     = count;
    // A push in a flush cycle is dropped, so it must not touch the storage either.
    assign push = q.in_valid && q.in_ready && !q.flush;
    assign pop  = q.out_valid && q.out_ready;

    // Storage needs no reset: the head is gated to 0 whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    always_ff @(posedge clk) begin
        if (!rstn || q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = q.out_valid ? mem[rd_ptr] : '0;

    assign q.out_instr  = head.instr;
    assign q.out_pc     = head.pc;
    assign q.result_src = head.result_src;
    assign q.mem_write  = head.mem_write;
    assign q.alu_src    = head.alu_src;
    assign q.imm_src    = head.imm_src;
    assign q.reg_write  = head.reg_write;
    assign q.branch     = head.branch;
    assign q.jump       = head.jump;
    assign q.alu_ctl    = head.alu_ctl;
    assign q.fpu_ctl    = head.fpu_ctl;
    assign q.is_fpu     = head.is_fpu;
    assign q.is_jalr    = head.is_jalr;
    assign q.is_load    = head.is_load;
    assign q.is_in      = head.is_in;
    assign q.is_out     = head.is_out;
    assign q.illegal    = head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, decode sweep, fill, simultaneous push/pop,
// wrap-around streaming with a PC scoreboard, and flush.
module tb_decode_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    decode_queue_if #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) bus ();

    decode_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32), .OP_LSB(0), .F3_LSB(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .q    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {result_src, mem_write, alu_src, imm_src, reg_write, branch, jump, illegal}
    logic [12:0] dec_tab [16];
    logic [31:0] exp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [12:0] obs_v;
        logic [4:0]  exp_fpu;
        logic        exp_isf;
        int          sent, rcvd, cyc;
        logic        pu, po;

        dec_tab = '{
            13'b001_0_1_000_1_0_0_0,  // LW
            13'b000_0_1_000_1_0_0_0,  // I
            13'b010_0_1_000_1_0_1_0,  // JALR
            13'b011_0_0_001_1_0_0_0,  // LUI
            13'b100_0_0_001_1_0_0_0,  // AUIPC
            13'b000_1_1_010_0_0_0_0,  // S
            13'b000_0_0_111_1_0_0_0,  // R
            13'b000_0_1_011_0_1_0_0,  // BI
            13'b000_0_0_010_0_1_0_0,  // B
            13'b010_0_0_100_1_0_1_0,  // JAL
            13'b001_0_0_111_1_0_0_0,  // IN
            13'b000_0_0_111_0_0_0_0,  // OUT
            13'b000_0_0_111_1_0_0_0,  // RF
            13'b000_0_0_111_1_0_0_0,  // C
            13'b000_0_0_010_0_1_0_0,  // BF
            13'b111_0_0_111_0_0_0_1   // illegal
        };

        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h0;
        bus.in_pc = 32'h100;
        bus.out_ready = 1'b0;

        // reset held two cycles with in_valid asserted
        step();
        step();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        rstn = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_count", 32'(bus.count), 32'd0);

        // decode sweep: each new push replaces the previous head (push+pop each edge)
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op = 4'(i);
            bus.in_valid = 1'b1;
            bus.in_instr = {20'hABCDE, 5'd0, 3'b101, op} | 32'h0;
            bus.in_pc = 32'(i * 4);
            step();
            obs_v = {bus.result_src, bus.mem_write, bus.alu_src, bus.imm_src,
                     bus.reg_write, bus.branch, bus.jump, bus.illegal};
            exp_isf = (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
            exp_fpu = exp_isf ? {op[1:0], 3'b101} : 5'b11111;
            chk($sformatf("dec_ctl_op%0h", op), 32'(obs_v), 32'(dec_tab[i]));
            chk($sformatf("dec_fpu_op%0h", op), 32'({bus.is_fpu, bus.fpu_ctl}), 32'({exp_isf, exp_fpu}));
            chk($sformatf("dec_oneh_op%0h", op), 32'({bus.is_jalr, bus.is_load, bus.is_in, bus.is_out}),
                32'({op == 4'h2, op == 4'h0, op == 4'hA, op == 4'hB}));
            chk($sformatf("dec_alu_op%0h", op), 32'(bus.alu_ctl), 32'd5);
            chk($sformatf("dec_pc_op%0h", op), bus.out_pc, 32'(i * 4));
            chk($sformatf("dec_instr_op%0h", op), bus.out_instr, {20'hABCDE, 5'd0, 3'b101, op});
            chk($sformatf("dec_count_op%0h", op), 32'(bus.count), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("sweep_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("sweep_empty_illegal", 32'(bus.illegal), 32'd0);
        chk("sweep_empty_fpu", 32'(bus.fpu_ctl), 32'd0);

        // fill to DEPTH, then offer a fifth
        bus.out_ready = 1'b0;
        bus.in_instr = 32'h0000_0001;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pc = 32'(i * 4);
            step();
        end
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_pc = 32'd16;
        step();
        chk("fill_fifth_count", 32'(bus.count), 32'd4);
        chk("fill_head_hold", bus.out_pc, 32'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain_pc%0d", i), bus.out_pc, 32'(i * 4));
            step();
        end
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // simultaneous push and pop at count=2
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h20; step();
        bus.in_pc = 32'h24; step();
        chk("sim_pre_count", 32'(bus.count), 32'd2);
        bus.in_pc = 32'h28;
        bus.out_ready = 1'b1;
        step();
        chk("sim_count", 32'(bus.count), 32'd2);
        chk("sim_head", bus.out_pc, 32'h24);
        bus.in_valid = 1'b0;
        step();
        chk("sim_last", bus.out_pc, 32'h28);
        step();
        chk("sim_empty", 32'(bus.count), 32'd0);

        // wrap: stream 3*DEPTH with random handshakes against a PC scoreboard
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 3 * DEPTH && cyc < 500) begin
            bus.in_valid = (sent < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
            bus.in_pc = 32'h1000 + 32'(sent * 4);
            bus.in_instr = $urandom();
            bus.out_ready = ($urandom_range(0, 1) == 1);
            #1;
            pu = bus.in_valid && bus.in_ready;
            po = bus.out_valid && bus.out_ready;
            if (po) begin
                if (exp_q.size() == 0) chk("wrap_spurious", bus.out_pc, 32'hFFFF_FFFF);
                else chk($sformatf("wrap_pc%0d", rcvd), bus.out_pc, exp_q.pop_front());
                rcvd++;
            end
            if (pu) begin
                exp_q.push_back(bus.in_pc);
                sent++;
            end
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("wrap_received", 32'(rcvd), 32'(3 * DEPTH));
        chk("wrap_empty", 32'(bus.count), 32'd0);

        // flush at count=3 with a concurrent push
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_pc = 32'h200 + 32'(i * 4);
            step();
        end
        chk("flush_pre_count", 32'(bus.count), 32'd3);
        bus.flush = 1'b1;
        bus.in_pc = 32'h20C;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("flush_no_ghost", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h300;
        step();
        bus.in_valid = 1'b0;
        chk("post_flush_head", bus.out_pc, 32'h300);
        chk("post_flush_count", 32'(bus.count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
